// File: rtl/fetch_prefetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_prefetch_unit
//
// Instruction-fetch front end. Owns the program counter, issues one word
// fetch at a time to instruction memory (req/gnt/rvalid handshake) and
// buffers returned instructions with their PCs in a DEPTH-entry queue that
// feeds decode. A redirect flushes the queue, restarts fetch at the new PC
// and causes any response still in flight to be discarded.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   redirect            flush queue and restart fetch at redirect_pc
//   redirect_pc         new PC (bits [1:0] ignored)
//   imem_req/addr       fetch request and word-aligned address
//   imem_gnt            memory accepts the request this cycle
//   imem_rvalid/rdata   response strobe and instruction word
//   inst_valid/ready    queue head valid / consumed by decode
//   inst, inst_pc       head instruction and its PC
//   count               queue occupancy
// ---------------------------------------------------------------------------
module fetch_prefetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     imem_req,
    output logic [XLEN-1:0]          imem_addr,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [31:0]              imem_rdata,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [31:0]              inst,
    output logic [XLEN-1:0]          inst_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // ST_WAIT: granted request whose response will be queued.
    // ST_DRAIN: granted request whose response must be thrown away.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          state_r;
    logic [XLEN-1:0] fetch_pc_r;
    logic [XLEN-1:0] req_pc_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [CW-1:0]   count_r;
    logic [XLEN-1:0] pc_mem_r   [DEPTH];
    logic [31:0]     word_mem_r [DEPTH];

    logic grant_s;
    logic push_s;
    logic pop_s;

    // The request is withheld while reset is held so nothing leaks out
    // before the front end is live; it only depends on local state and redirect.
    assign imem_req   = (state_r == ST_IDLE) && (count_r < CW'(DEPTH)) && !redirect && !rst;
    assign imem_addr  = fetch_pc_r;
    assign grant_s    = imem_req && imem_gnt;
    // A response in the redirect cycle belongs to the old stream: never queued.
    assign push_s     = (state_r == ST_WAIT) && imem_rvalid && !redirect;
    assign inst_valid = (count_r != {CW{1'b0}});
    assign pop_s      = inst_valid && inst_ready && !redirect;
    assign inst       = word_mem_r[rd_ptr_r];
    assign inst_pc    = pc_mem_r[rd_ptr_r];
    assign count      = count_r;

    // Queue storage write port; contents need no reset because count gates validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_r[wr_ptr_r]   <= req_pc_r;
            word_mem_r[wr_ptr_r] <= imem_rdata;
        end
    end

    // Fetch FSM, PC and queue bookkeeping; redirect overrides everything else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            fetch_pc_r <= RESET_PC;
            req_pc_r   <= RESET_PC;
            rd_ptr_r   <= {PW{1'b0}};
            wr_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
        end else if (redirect) begin
            fetch_pc_r <= {redirect_pc[XLEN-1:2], 2'b00};
            rd_ptr_r   <= {PW{1'b0}};
            wr_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            // The outstanding response, if any, must still be absorbed.
            case (state_r)
                ST_IDLE:  state_r <= ST_IDLE;
                ST_WAIT:  state_r <= imem_rvalid ? ST_IDLE : ST_DRAIN;
                ST_DRAIN: state_r <= imem_rvalid ? ST_IDLE : ST_DRAIN;
                default:  state_r <= ST_IDLE;
            endcase
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        req_pc_r   <= fetch_pc_r;
                        fetch_pc_r <= fetch_pc_r + XLEN'(4);
                        state_r    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (imem_rvalid) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/fetch_prefetch_unit.md
# fetch_prefetch_unit

Parametrised instruction-fetch front end for the RISC-V core. It owns the program counter, issues word fetches to instruction memory over a request/grant/response handshake, and buffers returned instructions in a DEPTH-entry prefetch queue ahead of decode. Branch/jump redirects flush the queue and discard any in-flight response. This replaces the single-cycle PC register and PC+4 path with a latency-tolerant fetch stage.

## Interface
- XLEN, 32, PC/address width (≥ 32)
- DEPTH, 4, prefetch queue entries; power of two, ≥ 2
- RESET_PC, 0, PC after reset; low two bits must be 0
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  XLEN  new PC; bits [1:0] ignored (forced 0)
- imem_req  out  1  fetch request valid
- imem_addr  out  XLEN  word-aligned fetch address
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  32  fetched instruction word
- inst_valid  out  1  queue head valid
- inst_ready  in  1  decode consumes head
- inst  out  32  head instruction
- inst_pc  out  XLEN  PC of head instruction
- count  out  $clog2(DEPTH)+1  queue occupancy

## Operation
- Registers: fetch_pc, req_pc, FIFO storage {pc, word} × DEPTH, rd/wr pointers, count, FSM.
- FSM states: IDLE (nothing outstanding), WAIT (one request granted, response pending), DRAIN (one request outstanding, response to be dropped). At most one outstanding request.
- Issue: imem_req = (state==IDLE) & (count < DEPTH) & !redirect; imem_addr = fetch_pc. Once asserted, req/addr stay stable until gnt or redirect.
- Grant (imem_req & imem_gnt): req_pc ← fetch_pc, fetch_pc ← fetch_pc + 4 (mod 2^XLEN, wraps silently), IDLE → WAIT.
- Response in WAIT with imem_rvalid: push {req_pc, imem_rdata}, WAIT → IDLE. Slot guaranteed since issue required count < DEPTH.
- Response in DRAIN: data dropped, DRAIN → IDLE.
- imem_rvalid in IDLE: ignored.
- Redirect (highest priority): count ← 0, pointers ← 0, fetch_pc ← {redirect_pc[XLEN-1:2], 2'b00}; WAIT → DRAIN; DRAIN stays DRAIN; IDLE stays IDLE. A response arriving in the redirect cycle is dropped and the FSM goes to IDLE.
- Pop: inst_valid = (count != 0); pop on inst_valid & inst_ready & !redirect. inst/inst_pc show head combinationally from storage.
- Simultaneous push and pop: count unchanged, both pointers advance (pointer wrap modulo DEPTH).
- Pop on empty and push on full cannot occur; no error flag.

## Timing
- Reset values: fetch_pc = RESET_PC, state IDLE, count 0, inst_valid 0, imem_req 0 while rst high; first cycle after release imem_req = 1, imem_addr = RESET_PC.
- imem_req/imem_addr depend combinationally only on state, count, fetch_pc and redirect; no combinational path from imem_gnt, imem_rvalid or inst_ready to any output.
- Response may arrive any cycle ≥ 1 after grant.
- Minimum redirect-to-instruction latency: redirect cycle N, req+gnt N+1, rvalid N+2, inst_valid N+3 with inst_pc = redirect target.
- Steady-state throughput with 1-cycle memory: one instruction per 2 cycles (single outstanding request).
- Reset asserted mid-transaction: all state returns to reset values immediately; any later rvalid is ignored (IDLE).

## Test plan
- Reset release, gnt=1, rvalid one cycle after each gnt, inst_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8…; inst_pc matches; first inst_valid 3 cycles after reset release.
- inst_ready=0, DEPTH=4 -> exactly 4 grants, count reaches 4, imem_req stays 0; assert inst_ready -> entries leave in order 0x0…0xC, fetch resumes at 0x10.
- Redirect to 0x103 while in WAIT, response arrives 3 cycles later with 0xDEADBEEF -> response dropped, queue empty, next imem_addr = 0x100, first inst_pc = 0x100.
- Redirect in the same cycle as imem_rvalid and inst_ready -> nothing pushed or popped, count = 0, next request to the redirect target.
- Hold imem_gnt=0 for 5 cycles -> imem_req and imem_addr stable throughout; fetch_pc increments only on the grant cycle.
- fetch_pc = 0xFFFFFFFC granted -> next imem_addr = 0x0; rst asserted while WAIT -> inst_valid 0, count 0, stray rvalid ignored.
